// File: rtl/game_board_store.sv
// Maze tile store: ROM reload, game-logic write-back, two registered
// read ports and a live food-tile count.
module game_board_store #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4,
    parameter int NUM_CELLS = 868,
    parameter logic [DATA_W-1:0] FOOD_CODE = 4'd1,
    parameter logic [DATA_W-1:0] OOR_CODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    output logic              board_loaded,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_dropped,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic [9:0]        food_count,
    output logic              all_food_eaten
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CELLS - 1);
    localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(NUM_CELLS);
    localparam logic [9:0] CNT_MAX = 10'(NUM_CELLS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t state;
    state_t stateNext;

    logic [DATA_W-1:0] mem [NUM_CELLS];
    logic              foodMap [NUM_CELLS];

    logic [ADDR_W-1:0] loadCyc;
    logic [ADDR_W-1:0] loadAddr;
    logic              startLoad;
    logic              loadWr;
    logic              loadDone;
    logic              wrOk;
    logic              oldFood;
    logic              newFood;
    logic              romFood;

    // loadCyc counts edges since the sampling edge; ROM word k lands at k+2
    assign startLoad = load_start && (state != LOAD);
    assign loadWr    = (state == LOAD) && (loadCyc != '0);
    assign loadDone  = (state == LOAD) && (loadCyc == CELLS);
    assign loadAddr  = loadCyc - 1'b1;
    assign romFood   = (rom_data == FOOD_CODE);

    assign wrOk = (state == READY) && wr_en && !load_start
               && (wr_addr <= LAST);
    assign oldFood = foodMap[wr_addr];
    assign newFood = (wr_data == FOOD_CODE);

    assign board_loaded   = (state == READY);
    assign all_food_eaten = board_loaded && (food_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (load_start) stateNext = LOAD;
            LOAD:    if (loadDone) stateNext = READY;
            READY:   if (load_start) stateNext = LOAD;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr   <= '0;
            loadCyc    <= '0;
            wr_dropped <= 1'b0;
            food_count <= '0;
            rd_data    <= '0;
            vga_data   <= '0;
        end else begin
            wr_dropped <= wr_en && !wrOk;
            rd_data  <= (rd_addr <= LAST) ? mem[rd_addr] : OOR_CODE;
            vga_data <= (vga_addr <= LAST) ? mem[vga_addr] : OOR_CODE;
            if (startLoad) begin
                rom_addr   <= '0;
                loadCyc    <= '0;
                food_count <= '0;
            end else if (state == LOAD) begin
                loadCyc <= loadCyc + 1'b1;
                if (rom_addr != LAST) begin
                    rom_addr <= rom_addr + 1'b1;
                end
                if (loadWr && romFood && food_count != CNT_MAX) begin
                    food_count <= food_count + 1'b1;
                end
            end else if (wrOk) begin
                if (oldFood && !newFood && food_count != '0) begin
                    food_count <= food_count - 1'b1;
                end else if (!oldFood && newFood
                             && food_count != CNT_MAX) begin
                    food_count <= food_count + 1'b1;
                end
            end
        end
    end

    // Tile contents survive reset; only the control state is cleared
    always_ff @(posedge clk) begin
        if (loadWr) begin
            mem[loadAddr]     <= rom_data;
            foodMap[loadAddr] <= romFood;
        end else if (wrOk) begin
            mem[wr_addr]     <= wr_data;
            foodMap[wr_addr] <= newFood;
        end
    end

endmodule

// File: tb/tb_game_board_store.sv
// Bench for game_board_store: transaction-level board model checked
// every cycle, plus directed literal checks.
module tb_game_board_store;

    localparam int N = 868;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic       board_loaded;
    logic [9:0] rom_addr;
    logic [3:0] rom_data = 4'd0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = 10'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dropped;
    logic [9:0] rd_addr = 10'd0;
    logic [3:0] rd_data;
    logic [9:0] vga_addr = 10'd0;
    logic [3:0] vga_data;
    logic [9:0] food_count;
    logic       all_food_eaten;

    int nChecks = 0;
    int nPass = 0;

    game_board_store dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .board_loaded(board_loaded),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_dropped(wr_dropped),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .vga_addr(vga_addr),
        .vga_data(vga_data),
        .food_count(food_count),
        .all_food_eaten(all_food_eaten)
    );

    always #5 clk = ~clk;

    // Initial-board ROM: food on every third tile below 720 (240 tiles)
    logic [3:0] rom [N];
    initial begin
        for (int i = 0; i < N; i++) begin
            if (i % 3 == 0 && i < 720) rom[i] = 4'd1;
            else if (i % 3 == 1) rom[i] = 4'd2;
            else rom[i] = 4'd0;
        end
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    // Board model, advanced once per clock edge from the sampled inputs
    typedef enum {M_IDLE, M_LOAD, M_READY} mst_t;
    mst_t mState = M_IDLE;
    logic [3:0] mdl [N];
    bit   known [N];
    int   cyc = 0;
    int   loadAt = 0;
    int   eRom = 0;
    int   eCount = 0;
    logic eDrop = 1'b0;
    logic [3:0] eRd = 4'd0;
    logic [3:0] eVga = 4'd0;
    bit   eRdK = 1'b1;
    bit   eVgaK = 1'b1;

    always @(posedge clk or negedge reset) begin
        int j;
        bit acc;
        if (!reset) begin
            mState = M_IDLE;
            eRom = 0;
            eCount = 0;
            eDrop = 1'b0;
            eRd = 4'd0;
            eVga = 4'd0;
            eRdK = 1'b1;
            eVgaK = 1'b1;
        end else begin
            cyc++;
            eRdK  = (rd_addr >= N) || known[rd_addr];
            eRd   = (rd_addr >= N) ? 4'hF : mdl[rd_addr];
            eVgaK = (vga_addr >= N) || known[vga_addr];
            eVga  = (vga_addr >= N) ? 4'hF : mdl[vga_addr];
            acc = (mState == M_READY) && wr_en && !load_start
                  && (wr_addr < N);
            eDrop = wr_en && !acc;
            if (mState != M_LOAD && load_start) begin
                mState = M_LOAD;
                loadAt = cyc;
                eRom = 0;
                eCount = 0;
            end else if (mState == M_LOAD) begin
                j = cyc - loadAt;
                eRom = (j < N - 1) ? j : N - 1;
                if (j >= 2) begin
                    mdl[j-2] = rom[j-2];
                    known[j-2] = 1'b1;
                end
                eCount = 0;
                for (int k = 0; k <= j - 2; k++)
                    if (rom[k] == 4'd1) eCount++;
                if (j == N + 1) mState = M_READY;
            end else if (acc) begin
                mdl[wr_addr] = wr_data;
                known[wr_addr] = 1'b1;
                eCount = 0;
                for (int k = 0; k < N; k++)
                    if (known[k] && mdl[k] == 4'd1) eCount++;
            end
        end
    end

    always @(negedge clk) begin
        chk("board_loaded", board_loaded, mState == M_READY);
        chk("rom_addr", rom_addr, eRom);
        chk("wr_dropped", wr_dropped, eDrop);
        chk("food_count", food_count, eCount);
        chk("all_food_eaten", all_food_eaten,
            (mState == M_READY) && (eCount == 0));
        if (eRdK) chk("rd_data", rd_data, eRd);
        if (eVgaK) chk("vga_data", vga_data, eVga);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitLoaded();
        int n;
        n = 0;
        while (!board_loaded && n < 2000) begin
            tick();
            n++;
        end
        chk("load_latency", n, 869);
    endtask

    task automatic doLoad();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        waitLoaded();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = 10'(a);
        wr_data = 4'(d);
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_loaded", board_loaded, 0);
        chk("rst_count", food_count, 0);
        chk("rst_rd", rd_data, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        tick();

        doLoad();
        chk("load_food", food_count, 240);
        for (int a = 0; a < N; a++) begin
            vga_addr = 10'(a);
            tick();
        end
        vga_addr = 10'd495;
        tick();
        chk("vga_495", vga_data, 1);

        rd_addr = 10'd495;
        wr_en = 1'b1;
        wr_addr = 10'd495;
        wr_data = 4'd0;
        tick();
        wr_en = 1'b0;
        chk("rd_first", rd_data, 1);
        tick();
        chk("rd_after", rd_data, 0);
        chk("erase_count", food_count, 239);

        wr(2, 1);
        chk("food_add", food_count, 240);
        wr(1, 2);
        chk("wall_wall", food_count, 240);

        rd_addr = 10'd900;
        wr(900, 1);
        chk("oor_drop", wr_dropped, 1);
        chk("oor_rd", rd_data, 4'hF);
        chk("oor_count", food_count, 240);
        tick();
        chk("oor_drop_end", wr_dropped, 0);
        rd_addr = 10'd0;

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (299) tick();
        reset = 1'b0;
        #1;
        chk("mid_loaded", board_loaded, 0);
        chk("mid_rom", rom_addr, 0);
        chk("mid_count", food_count, 0);
        chk("mid_rd", rd_data, 0);
        chk("mid_vga", vga_data, 0);
        chk("mid_drop", wr_dropped, 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
        doLoad();
        chk("reload_food", food_count, 240);

        load_start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 10'd10;
        wr_data = 4'd1;
        tick();
        load_start = 1'b0;
        wr_en = 1'b0;
        chk("sim_drop", wr_dropped, 1);
        chk("sim_loaded", board_loaded, 0);
        waitLoaded();
        chk("sim_food", food_count, 240);
        chk("sim_not_eaten", all_food_eaten, 0);

        for (int i = 0; i < 720; i += 3) wr(i, 0);
        tick();
        chk("eaten_count", food_count, 0);
        chk("all_eaten", all_food_eaten, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/game_board_store.md
Name: game_board_store

Overview:
- Owns the maze tile memory that sits between the game-logic FSM and the display.
- On request, it reloads the board from the initial-board ROM and signals completion to the game-logic FSM.
- It accepts tile write-backs (data2Write/writeAddr/writeEn) from the game-logic FSM.
- It serves registered tile reads to the game-logic FSM (Pac-Man next-tile lookup) and to the VGA renderer.
- It keeps a live count of remaining food tiles.

Parameters:
- ADDR_W, 10, tile address width.
- DATA_W, 4, tile code width.
- NUM_CELLS, 868, number of valid tiles (28x31); valid addresses are 0..NUM_CELLS-1.
- FOOD_CODE, 4'd1, tile code counted as food.
- OOR_CODE, 4'hF, code returned for out-of-range reads (treated as wall).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to (re)load the board from ROM.
- board_loaded  out  1  level; high while board contents are valid and the store is in READY.
- rom_addr  out  ADDR_W  initial-board ROM address.
- rom_data  in  DATA_W  ROM data; synchronous ROM, 1-cycle latency.
- wr_en  in  1  tile write strobe from game logic.
- wr_addr  in  ADDR_W  tile write address.
- wr_data  in  DATA_W  tile write data.
- wr_dropped  out  1  1-cycle pulse when a write strobe is discarded.
- rd_addr  in  ADDR_W  game-logic read address.
- rd_data  out  DATA_W  game-logic read data, 1-cycle latency.
- vga_addr  in  ADDR_W  renderer read address.
- vga_data  out  DATA_W  renderer read data, 1-cycle latency.
- food_count  out  10  food tiles currently on the board.
- all_food_eaten  out  1  board_loaded AND (food_count == 0).

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - board_loaded=0, rom_addr=0, wr_dropped=0, food_count=0, rd_data=0, vga_data=0.
  - Tile RAM contents are not cleared.
- FSM states: IDLE, LOAD, READY.
- IDLE:
  - Wait for load_start=1, then go to LOAD.
  - Writes are dropped, with wr_dropped pulsed.
- LOAD entry (edge E0 samples load_start):
  - rom_addr=0, food_count cleared to 0, board_loaded=0.
- LOAD stepping:
  - rom_addr increments once per cycle through NUM_CELLS-1, then holds.
  - The ROM word for address k is written to RAM[k] one cycle after it returns, i.e. at edge E(k+2).
  - food_count increments for each loaded word equal to FOOD_CODE.
- LOAD exit: after the write of address NUM_CELLS-1 at edge E(NUM_CELLS+1), the FSM enters READY and board_loaded=1.
  - Total latency: NUM_CELLS+1 cycles from the sampling edge.
- LOAD input handling:
  - load_start is ignored.
  - wr_en is dropped, with wr_dropped pulsed the following cycle.
- READY, load_start=1:
  - Go to LOAD with the same entry actions; board_loaded falls on the next edge.
  - A simultaneous wr_en is dropped (wr_dropped pulses).
- READY, wr_en=1 with wr_addr < NUM_CELLS: RAM[wr_addr] <= wr_data.
  - old==FOOD and new!=FOOD: food_count-1.
  - old!=FOOD and new==FOOD: food_count+1.
  - Otherwise food_count is unchanged.
  - A 1-bit food shadow map held in registers supplies "old" combinationally.
- food_count saturates at 0 and at NUM_CELLS; it never wraps.
- Out-of-range write (wr_addr >= NUM_CELLS): no RAM or count change, wr_dropped pulses.
- Read ports:
  - Both ports are independent and registered, valid one cycle after the address is presented, in every state.
  - Read-first: a read of an address written in the same cycle returns the old value.
  - Out-of-range read address returns OOR_CODE.
  - Reads during LOAD return the current (partially loaded) RAM contents.
- all_food_eaten is combinational from registered board_loaded and food_count.

Test Plan:
- Reset, then load_start pulse with a ROM image containing 240 FOOD tiles → board_loaded rises exactly 869 cycles after the sampling edge; food_count=240; vga reads of every address match the ROM.
- After the load, write EMPTY over a FOOD tile at address 495 → food_count 240→239; rd_addr=495 on the same cycle returns FOOD, on the next cycle returns EMPTY.
- Write FOOD over EMPTY, then write WALL over WALL → food_count increments by 1, then is unchanged.
- wr_addr=900 write and rd_addr=900 read → wr_dropped pulses once; rd_data=4'hF; food_count unchanged.
- Assert reset low at cycle 300 of a load → all outputs return to reset values immediately; a new load_start completes normally.
- In READY, assert load_start and wr_en in the same cycle → write dropped with wr_dropped pulsed; board reloads; food_count=240. Erase all food → all_food_eaten=1.
